// File: rtl/mii_frame_scheduler.sv
// mii_frame_scheduler
//
// Purpose:
//   Round-robin scheduler that hands out transmit slots to up to eight frame
//   requesters. A grant issues a one-cycle start pulse to the frame generator
//   with the clamped payload length. The scheduler then waits for the
//   generator's done pulse and enforces an inter-frame gap before granting
//   again.
//
// Build option:
//   FRAME_SCHED_WDOG_EN - when defined, a WAIT that lasts WDOG_CYCLES cycles
//   without i_done is aborted with an o_timeout pulse. When undefined, no
//   watchdog counter exists and o_timeout is tied low.
//
// Ports:
//   clk              in   single clock, rising edge
//   i_rst            in   asynchronous active-high reset
//   i_req            in   N_REQ   per-requester request level
//   i_len            in   16*N_REQ per-requester payload length (slice k = [16k+15:16k])
//   i_done           in   generator frame-complete pulse (honoured in WAIT only)
//   o_start          out  one-cycle start pulse to the generator
//   o_grant          out  N_REQ one-hot grant, coincident with o_start
//   o_sel            out  3  index of the granted requester
//   o_payload_length out  16 clamped payload length of the granted frame
//   o_len_err        out  pulse with o_start when the length was clamped down
//   o_busy           out  high in every state except IDLE
//   o_timeout        out  one-cycle watchdog abort pulse
//   o_frame_cnt      out  32 frames completed by i_done (wraps)
module mii_frame_scheduler #(
  parameter int N_REQ            = 4,
  parameter int PAYLOAD_MAX_SIZE = 1500,
  parameter int MIN_PAYLOAD      = 46,
  parameter int IFG_CYCLES       = 12,
  parameter int WDOG_CYCLES      = 4096
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [16*N_REQ-1:0]  i_len,
  input  logic                 i_done,
  output logic                 o_start,
  output logic [N_REQ-1:0]     o_grant,
  output logic [2:0]           o_sel,
  output logic [15:0]          o_payload_length,
  output logic                 o_len_err,
  output logic                 o_busy,
  output logic                 o_timeout,
  output logic [31:0]          o_frame_cnt
);

  typedef enum logic [1:0] {IDLE, START, WAIT, IFG} state_t;

  state_t     r_state;
  logic [2:0] r_rr_ptr;
  logic [7:0] r_ifg_cnt;

  logic [N_REQ-1:0] w_rot;
  logic [3:0]       w_sum;
  logic             w_any_req;
  logic [2:0]       w_pick;
  logic [2:0]       w_next_ptr;
  logic [N_REQ-1:0] w_grant_vec;
  logic [15:0]      w_raw_len;
  logic [15:0]      w_clamp_len;
  logic             w_len_over;

`ifdef FRAME_SCHED_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] r_wdog_cnt;
`endif

  // Round-robin pick: rotate the request vector so bit 0 is the requester at
  // rr_ptr, then take the lowest set bit. The descending loop lets the
  // smallest offset overwrite larger ones.
  always_comb begin
    w_any_req = |i_req;
    w_rot     = N_REQ'({i_req, i_req} >> r_rr_ptr);
    w_sum     = 4'd0;
    w_pick    = 3'd0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (w_rot[off]) begin
        w_sum = {1'b0, r_rr_ptr} + 4'(off);
        if (w_sum >= 4'(N_REQ)) begin
          w_sum = w_sum - 4'(N_REQ);
        end
        w_pick = w_sum[2:0];
      end
    end
    w_next_ptr = (w_pick == 3'(N_REQ - 1)) ? 3'd0 : w_pick + 3'd1;
  end

  // Select the winner's length and one-hot grant, then clamp the length.
  // Only the upper clamp counts as an error; short frames are simply padded.
  always_comb begin
    w_raw_len   = 16'd0;
    w_grant_vec = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_grant_vec[k] = (w_pick == 3'(k));
      if (w_pick == 3'(k)) begin
        w_raw_len = i_len[16*k +: 16];
      end
    end
    w_len_over  = 1'b0;
    if (w_raw_len > 16'(PAYLOAD_MAX_SIZE)) begin
      w_clamp_len = 16'(PAYLOAD_MAX_SIZE);
      w_len_over  = 1'b1;
    end else if (w_raw_len < 16'(MIN_PAYLOAD)) begin
      w_clamp_len = 16'(MIN_PAYLOAD);
    end else begin
      w_clamp_len = w_raw_len;
    end
  end

`ifndef FRAME_SCHED_WDOG_EN
  assign o_timeout = 1'b0;
`endif

  // Main FSM. Pulse outputs default low every cycle; o_sel and
  // o_payload_length change only on a grant so they stay valid for the
  // whole frame and gap.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state          <= IDLE;
      r_rr_ptr         <= 3'd0;
      r_ifg_cnt        <= 8'd0;
      o_start          <= 1'b0;
      o_grant          <= '0;
      o_sel            <= 3'd0;
      o_payload_length <= 16'd0;
      o_len_err        <= 1'b0;
      o_busy           <= 1'b0;
      o_frame_cnt      <= 32'd0;
`ifdef FRAME_SCHED_WDOG_EN
      r_wdog_cnt       <= '0;
      o_timeout        <= 1'b0;
`endif
    end else begin
      o_start   <= 1'b0;
      o_grant   <= '0;
      o_len_err <= 1'b0;
`ifdef FRAME_SCHED_WDOG_EN
      o_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_state          <= START;
            o_start          <= 1'b1;
            o_grant          <= w_grant_vec;
            o_sel            <= w_pick;
            o_payload_length <= w_clamp_len;
            o_len_err        <= w_len_over;
            o_busy           <= 1'b1;
            r_rr_ptr         <= w_next_ptr;
          end
        end
        START: begin
          r_state <= WAIT;
`ifdef FRAME_SCHED_WDOG_EN
          r_wdog_cnt <= '0;
`endif
        end
        WAIT: begin
          // A done on the expiry cycle takes priority over the watchdog.
          if (i_done) begin
            o_frame_cnt <= o_frame_cnt + 32'd1;
            r_state     <= IFG;
            r_ifg_cnt   <= 8'd0;
          end
`ifdef FRAME_SCHED_WDOG_EN
          else if (r_wdog_cnt == WDOG_W'(WDOG_CYCLES - 1)) begin
            o_timeout <= 1'b1;
            r_state   <= IFG;
            r_ifg_cnt <= 8'd0;
          end else begin
            r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
          end
`endif
        end
        IFG: begin
          if (r_ifg_cnt == 8'(IFG_CYCLES - 1)) begin
            r_state <= IDLE;
            o_busy  <= 1'b0;
          end else begin
            r_ifg_cnt <= r_ifg_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mii_frame_scheduler.sv
// Self-checking bench for mii_frame_scheduler. Expected grants, lengths,
// counts and timing come from a small behavioural model (round-robin search
// by modular arithmetic, clamping by comparison, gap lengths from the
// parameter values). Inputs are driven and outputs sampled on the falling
// edge.
module tb_mii_frame_scheduler;

  localparam int N    = 4;
  localparam int PMAX = 1500;
  localparam int PMIN = 46;
  localparam int IFG  = 12;
  localparam int WDOG = 4096;

  logic            clk;
  logic            i_rst;
  logic [N-1:0]    i_req;
  logic [16*N-1:0] i_len;
  logic            i_done;
  logic            o_start;
  logic [N-1:0]    o_grant;
  logic [2:0]      o_sel;
  logic [15:0]     o_payload_length;
  logic            o_len_err;
  logic            o_busy;
  logic            o_timeout;
  logic [31:0]     o_frame_cnt;

  int          n_tests;
  int          n_fail;
  int          exp_rr;
  logic [31:0] exp_cnt;

  mii_frame_scheduler #(
    .N_REQ(N), .PAYLOAD_MAX_SIZE(PMAX), .MIN_PAYLOAD(PMIN),
    .IFG_CYCLES(IFG), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_req(i_req), .i_len(i_len), .i_done(i_done),
    .o_start(o_start), .o_grant(o_grant), .o_sel(o_sel),
    .o_payload_length(o_payload_length), .o_len_err(o_len_err),
    .o_busy(o_busy), .o_timeout(o_timeout), .o_frame_cnt(o_frame_cnt)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the DUT wedges somewhere unexpected.
  initial begin
    #3_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, limit 3000000 ns");
    $fatal(1, "[TB] aborted");
  end

  // Reference: first requesting index at or after start, wrapping.
  function automatic int model_pick(input logic [N-1:0] req, input int start);
    for (int off = 0; off < N; off++) begin
      if (req[(start + off) % N]) return (start + off) % N;
    end
    return -1;
  endfunction

  function automatic logic [15:0] model_len(input int raw);
    if (raw < PMIN) return 16'(PMIN);
    if (raw > PMAX) return 16'(PMAX);
    return 16'(raw);
  endfunction

  function automatic logic model_err(input int raw);
    return raw > PMAX;
  endfunction

  function automatic int rand_len();
    int edges[4];
    edges = '{PMIN - 1, PMIN, PMAX, PMAX + 1};
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, PMIN - 1));
      1:       return int'($urandom_range(PMIN, PMAX));
      2:       return int'($urandom_range(PMAX + 1, 65535));
      default: return edges[$urandom_range(0, 3)];
    endcase
  endfunction

  // Stimulus only: from the START cycle, wait, pulse done, sit out the gap
  // and come back at the first IDLE cycle.
  task automatic finish_frame(input int wait_cyc);
    i_req = '0;
    repeat (wait_cyc) @(negedge clk);
    i_done = 1'b1;
    @(negedge clk);
    i_done  = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    repeat (IFG) @(negedge clk);
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_req = '0; i_len = '0; i_done = 1'b0;
    #1;
    n_tests++;
    if ({o_start, o_grant, o_len_err, o_busy, o_timeout} !== '0) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b, expected 0", {o_start, o_grant, o_len_err, o_busy, o_timeout});
    end
    n_tests++;
    if (o_sel !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_sel: got %0d, expected 0", o_sel); end
    n_tests++;
    if (o_payload_length !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_len: got %0d, expected 0", o_payload_length); end
    n_tests++;
    if (o_frame_cnt !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_cnt: got %0d, expected 0", o_frame_cnt); end
    @(negedge clk); @(negedge clk);
    i_rst = 1'b0; exp_rr = 0; exp_cnt = '0;
    @(negedge clk);
    n_tests++;
    if ({o_start, o_busy} !== 2'b00) begin n_fail++; $display("[TB] FAIL idle_after_reset: got %b, expected 00", {o_start, o_busy}); end
  endtask

  task automatic test_single();
    int gap;
    i_len = '0; i_len[16*2 +: 16] = 16'd100; i_req = 4'b0100;
    @(negedge clk);
    i_req = '0;
    n_tests++;
    if ({o_start, o_grant} !== 5'b1_0100) begin n_fail++; $display("[TB] FAIL single_grant: got %b, expected 10100", {o_start, o_grant}); end
    n_tests++;
    if (o_sel !== 3'd2) begin n_fail++; $display("[TB] FAIL single_sel: got %0d, expected 2", o_sel); end
    n_tests++;
    if ({o_payload_length, o_len_err} !== {16'd100, 1'b0}) begin n_fail++; $display("[TB] FAIL single_len: got %0d/%b, expected 100/0", o_payload_length, o_len_err); end
    exp_rr = 3;
    repeat (19) @(negedge clk);
    n_tests++;
    if ({o_start, o_busy} !== 2'b01) begin n_fail++; $display("[TB] FAIL single_wait: got %b, expected 01", {o_start, o_busy}); end
    i_done = 1'b1;
    @(negedge clk);
    i_done = 1'b0; exp_cnt = exp_cnt + 32'd1;
    n_tests++;
    if (o_frame_cnt !== exp_cnt) begin n_fail++; $display("[TB] FAIL single_cnt: got %0d, expected %0d", o_frame_cnt, exp_cnt); end
    // With the request held, the next start follows the gap plus one IDLE cycle.
    i_req = 4'b0100;
    gap = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (o_start === 1'b1) begin gap = c; break; end
    end
    i_req = '0;
    n_tests++;
    if (gap !== IFG + 1) begin n_fail++; $display("[TB] FAIL single_gap: got %0d, expected %0d", gap, IFG + 1); end
    n_tests++;
    if (o_grant !== 4'b0100) begin n_fail++; $display("[TB] FAIL single_regrant: got %b, expected 0100", o_grant); end
    exp_rr = 3;
    finish_frame(3);
  endtask

  task automatic test_length_clamp();
    int lens[8];
    logic [N-1:0] req;
    int idx;
    lens = '{10, 2000, PMIN - 1, PMIN, PMAX, PMAX + 1, 0, 65535};
    foreach (lens[t]) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      idx = model_pick(req, exp_rr);
      for (int k = 0; k < N; k++) i_len[16*k +: 16] = 16'(rand_len());
      i_len[16*idx +: 16] = 16'(lens[t]);
      i_req = req;
      @(negedge clk);
      n_tests++;
      if ({o_start, o_sel} !== {1'b1, 3'(idx)}) begin n_fail++; $display("[TB] FAIL clamp_grant: got %b/%0d, expected 1/%0d", o_start, o_sel, idx); end
      n_tests++;
      if (o_payload_length !== model_len(lens[t])) begin n_fail++; $display("[TB] FAIL clamp_len(%0d): got %0d, expected %0d", lens[t], o_payload_length, model_len(lens[t])); end
      n_tests++;
      if (o_len_err !== model_err(lens[t])) begin n_fail++; $display("[TB] FAIL clamp_err(%0d): got %b, expected %b", lens[t], o_len_err, model_err(lens[t])); end
      exp_rr = (idx + 1) % N;
      finish_frame(int'($urandom_range(1, 4)));
    end
  endtask

  task automatic test_round_robin();
    int order[5];
    int gap;
    order = '{0, 1, 2, 3, 0};
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0; exp_rr = 0; exp_cnt = '0;
    for (int k = 0; k < N; k++) i_len[16*k +: 16] = 16'(64 + 8 * k);
    i_req = '1;
    for (int g = 0; g < 5; g++) begin
      gap = 0;
      for (int c = 1; c <= 100; c++) begin
        @(negedge clk);
        if (o_start === 1'b1) begin gap = c; break; end
      end
      if (g == 4) i_req = '0;
      n_tests++;
      if (gap !== ((g == 0) ? 1 : IFG + 1)) begin n_fail++; $display("[TB] FAIL rr_gap[%0d]: got %0d, expected %0d", g, gap, (g == 0) ? 1 : IFG + 1); end
      n_tests++;
      if ({o_sel, o_grant} !== {3'(order[g]), N'(1 << order[g])}) begin n_fail++; $display("[TB] FAIL rr_order[%0d]: got %0d/%b, expected %0d", g, o_sel, o_grant, order[g]); end
      exp_rr = (model_pick(4'b1111, exp_rr) + 1) % N;
      // Done held across START and WAIT: only the WAIT sample may count.
      i_done = 1'b1;
      @(negedge clk); @(negedge clk);
      i_done = 1'b0; exp_cnt = exp_cnt + 32'd1;
      n_tests++;
      if (o_frame_cnt !== exp_cnt) begin n_fail++; $display("[TB] FAIL rr_cnt[%0d]: got %0d, expected %0d", g, o_frame_cnt, exp_cnt); end
    end
    repeat (IFG) @(negedge clk);
  endtask

  task automatic test_done_ignored();
    i_req = '0; i_done = 1'b1;
    repeat (3) @(negedge clk);
    i_done = 1'b0;
    n_tests++;
    if ({o_busy, o_start, o_frame_cnt} !== {2'b00, exp_cnt}) begin n_fail++; $display("[TB] FAIL idle_done: got busy %b cnt %0d, expected 0/%0d", o_busy, o_frame_cnt, exp_cnt); end
    i_req = 4'b0001;
    @(negedge clk);
    i_req = '0;
    exp_rr = 1;
    @(negedge clk);
    i_done = 1'b1;
    @(negedge clk);
    exp_cnt = exp_cnt + 32'd1;
    repeat (IFG - 1) @(negedge clk);
    n_tests++;
    if ({o_busy, o_frame_cnt} !== {1'b1, exp_cnt}) begin n_fail++; $display("[TB] FAIL ifg_done: got busy %b cnt %0d, expected 1/%0d", o_busy, o_frame_cnt, exp_cnt); end
    i_done = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({o_busy, o_frame_cnt} !== {1'b0, exp_cnt}) begin n_fail++; $display("[TB] FAIL ifg_end: got busy %b cnt %0d, expected 0/%0d", o_busy, o_frame_cnt, exp_cnt); end
  endtask

  task automatic test_random_traffic();
    logic [N-1:0] req;
    int raw[N];
    int idx;
    int w;
    logic [15:0] held_len;
    logic [2:0]  held_sel;
    for (int it = 0; it < 30; it++) begin
      req = (it % 5 == 0) ? '0 : N'($urandom_range(0, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        raw[k] = rand_len();
        i_len[16*k +: 16] = 16'(raw[k]);
      end
      i_req  = req;
      i_done = (req == '0) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      i_done = 1'b0;
      if (req == '0) begin
        n_tests++;
        if ({o_start, o_busy, o_frame_cnt} !== {2'b00, exp_cnt}) begin n_fail++; $display("[TB] FAIL rnd_idle[%0d]: got %b/%b/%0d, expected 0/0/%0d", it, o_start, o_busy, o_frame_cnt, exp_cnt); end
        continue;
      end
      idx      = model_pick(req, exp_rr);
      held_sel = 3'(idx);
      held_len = model_len(raw[idx]);
      n_tests++;
      if ({o_start, o_grant, o_sel, o_busy} !== {1'b1, N'(1 << idx), held_sel, 1'b1}) begin n_fail++; $display("[TB] FAIL rnd_grant[%0d]: got %b/%b/%0d, expected grant %0d", it, o_start, o_grant, o_sel, idx); end
      n_tests++;
      if ({o_payload_length, o_len_err} !== {held_len, model_err(raw[idx])}) begin n_fail++; $display("[TB] FAIL rnd_len[%0d]: got %0d/%b, expected %0d/%b", it, o_payload_length, o_len_err, held_len, model_err(raw[idx])); end
      exp_rr = (idx + 1) % N;
      w = int'($urandom_range(1, 25));
      for (int c = 0; c < w; c++) begin
        i_req = N'($urandom_range(0, (1 << N) - 1));
        @(negedge clk);
        n_tests++;
        if ({o_start, o_grant, o_len_err, o_busy, o_timeout, o_sel, o_payload_length} !== {1'b0, {N{1'b0}}, 3'b010, held_sel, held_len}) begin
          n_fail++; $display("[TB] FAIL rnd_wait[%0d]: got start %b busy %b sel %0d len %0d, expected hold %0d/%0d", it, o_start, o_busy, o_sel, o_payload_length, held_sel, held_len);
        end
      end
      i_done = 1'b1;
      @(negedge clk);
      exp_cnt = exp_cnt + 32'd1;
      n_tests++;
      if ({o_busy, o_frame_cnt} !== {1'b1, exp_cnt}) begin n_fail++; $display("[TB] FAIL rnd_cnt[%0d]: got %b/%0d, expected 1/%0d", it, o_busy, o_frame_cnt, exp_cnt); end
      // Gap: random requests and stray done pulses must have no effect.
      for (int j = 1; j <= IFG; j++) begin
        i_req  = N'($urandom_range(0, (1 << N) - 1));
        i_done = 1'($urandom_range(0, 1));
        @(negedge clk);
        n_tests++;
        if ({o_start, o_busy, o_frame_cnt} !== {1'b0, (j < IFG), exp_cnt}) begin n_fail++; $display("[TB] FAIL rnd_ifg[%0d.%0d]: got %b/%b/%0d, expected 0/%b/%0d", it, j, o_start, o_busy, o_frame_cnt, j < IFG, exp_cnt); end
      end
      i_req = '0; i_done = 1'b0;
    end
  endtask

  task automatic test_reset_mid_frame();
    i_req = 4'b0010;
    @(negedge clk);
    exp_rr = 2;
    finish_frame(2);
    i_req = 4'b0010;
    @(negedge clk);
    n_tests++;
    if (o_sel !== 3'd1) begin n_fail++; $display("[TB] FAIL mid_pre_sel: got %0d, expected 1", o_sel); end
    i_req = '0;
    repeat (3) @(negedge clk);
    #2 i_rst = 1'b1;
    #1;
    n_tests++;
    if ({o_start, o_grant, o_sel, o_payload_length, o_len_err, o_busy, o_timeout, o_frame_cnt} !== '0) begin
      n_fail++; $display("[TB] FAIL mid_reset_async: got busy %b sel %0d len %0d cnt %0d, expected all 0", o_busy, o_sel, o_payload_length, o_frame_cnt);
    end
    @(negedge clk); @(negedge clk);
    i_rst = 1'b0; i_req = 4'b1100; exp_rr = 0; exp_cnt = '0;
    @(negedge clk);
    n_tests++;
    if ({o_start, o_grant, o_sel} !== {1'b1, 4'b0100, 3'd2}) begin n_fail++; $display("[TB] FAIL mid_regrant: got %b/%b/%0d, expected 1/0100/2", o_start, o_grant, o_sel); end
    n_tests++;
    if ({o_timeout, o_frame_cnt} !== 33'd0) begin n_fail++; $display("[TB] FAIL mid_cnt: got %b/%0d, expected 0/0", o_timeout, o_frame_cnt); end
    exp_rr = 3;
    finish_frame(1);
  endtask

`ifdef FRAME_SCHED_WDOG_EN
  task automatic test_watchdog();
    int bad;
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0; exp_rr = 0; exp_cnt = '0;
    i_req = 4'b0001;
    @(negedge clk);
    i_req = '0;
    n_tests++;
    if (o_start !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_start: got %b, expected 1", o_start); end
    bad = 0;
    for (int c = 1; c <= WDOG; c++) begin
      @(negedge clk);
      if (o_timeout !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL wd_early: got %0d early timeout cycles, expected 0", bad); end
    @(negedge clk);
    n_tests++;
    if ({o_timeout, o_busy, o_frame_cnt} !== {2'b11, 32'd0}) begin n_fail++; $display("[TB] FAIL wd_expire: got %b/%b/%0d, expected 1/1/0", o_timeout, o_busy, o_frame_cnt); end
    @(negedge clk);
    n_tests++;
    if (o_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_pulse: got %b, expected 0", o_timeout); end
    repeat (IFG - 1) @(negedge clk);
    n_tests++;
    if (o_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_ifg: got %b, expected 0", o_busy); end
    // Second run: done lands on the expiry cycle and must win.
    i_req = 4'b0001;
    @(negedge clk);
    i_req = '0;
    bad = 0;
    for (int c = 1; c <= WDOG; c++) begin
      @(negedge clk);
      if (o_timeout !== 1'b0) bad++;
    end
    i_done = 1'b1;
    @(negedge clk);
    i_done = 1'b0; exp_cnt = exp_cnt + 32'd1;
    if (o_timeout !== 1'b0) bad++;
    @(negedge clk);
    if (o_timeout !== 1'b0) bad++;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL wd_race_timeout: got %0d timeout cycles, expected 0", bad); end
    n_tests++;
    if (o_frame_cnt !== exp_cnt) begin n_fail++; $display("[TB] FAIL wd_race_cnt: got %0d, expected %0d", o_frame_cnt, exp_cnt); end
    repeat (IFG - 1) @(negedge clk);
  endtask
`else
  task automatic test_no_watchdog();
    int bad;
    i_req = 4'b1000;
    @(negedge clk);
    i_req = '0;
    n_tests++;
    if ({o_start, o_sel} !== {1'b1, 3'd3}) begin n_fail++; $display("[TB] FAIL nowd_grant: got %b/%0d, expected 1/3", o_start, o_sel); end
    exp_rr = 0;
    bad = 0;
    for (int c = 1; c <= WDOG + 50; c++) begin
      @(negedge clk);
      if ({o_timeout, o_start, o_busy} !== 3'b001) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("[TB] FAIL nowd_wait: got %0d bad cycles, expected 0", bad); end
    i_done = 1'b1;
    @(negedge clk);
    i_done = 1'b0; exp_cnt = exp_cnt + 32'd1;
    n_tests++;
    if ({o_timeout, o_frame_cnt} !== {1'b0, exp_cnt}) begin n_fail++; $display("[TB] FAIL nowd_cnt: got %b/%0d, expected 0/%0d", o_timeout, o_frame_cnt, exp_cnt); end
    repeat (IFG) @(negedge clk);
  endtask
`endif

  initial begin
    n_tests = 0; n_fail = 0; exp_rr = 0; exp_cnt = '0;
    test_reset();
    test_single();
    test_length_clamp();
    test_round_robin();
    test_done_ignored();
    test_random_traffic();
    test_reset_mid_frame();
`ifdef FRAME_SCHED_WDOG_EN
    test_watchdog();
`else
    test_no_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mii_frame_scheduler.md
MII_FRAME_SCHEDULER -- requirements
Module: mii_frame_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of frame requesters, range 2..8.
REQ-002 Parameter PAYLOAD_MAX_SIZE, default 1500: maximum payload bytes accepted.
REQ-003 Parameter MIN_PAYLOAD, default 46: minimum payload bytes issued.
REQ-004 Parameter IFG_CYCLES, default 12: idle cycles between frames, range 1..255.
REQ-005 Parameter WDOG_CYCLES, default 4096: watchdog limit in cycles.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 i_rst  input  1  asynchronous, active-high reset.
REQ-008 i_req  input  N_REQ  per-requester frame request level.
REQ-009 i_len  input  16*N_REQ  per-requester payload length; slice k at bits [16k+15:16k].
REQ-010 i_done  input  1  generator frame-complete pulse.
REQ-011 o_start  output  1  one-cycle start pulse to the frame generator.
REQ-012 o_grant  output  N_REQ  one-hot grant pulse, coincident with o_start.
REQ-013 o_sel  output  3  index of the granted requester.
REQ-014 o_payload_length  output  16  clamped length for the granted frame.
REQ-015 o_len_err  output  1  one-cycle pulse when a length was clamped.
REQ-016 o_busy  output  1  high in every state except IDLE.
REQ-017 o_timeout  output  1  one-cycle watchdog abort pulse.
REQ-018 o_frame_cnt  output  32  count of frames completed by i_done.

Function
REQ-019 The FSM SHALL have the states IDLE, START, WAIT and IFG; all outputs SHALL be registered.
REQ-020 IDLE with any i_req bit high SHALL go to START on the next edge, granting the first requester at or after rr_ptr in ascending index order with wrap-around.
REQ-021 In START, o_start and the o_grant bit SHALL be high for exactly one cycle; the FSM SHALL then go to WAIT.
REQ-022 On the START entry edge, rr_ptr SHALL become (granted index + 1) mod N_REQ.
REQ-023 Latency SHALL be exactly one cycle from the sampled request in IDLE to o_start high.
REQ-024 o_sel and o_payload_length SHALL be loaded on the START entry edge and held until the next grant.
REQ-025 A length below MIN_PAYLOAD SHALL be issued as MIN_PAYLOAD, with no o_len_err.
REQ-026 A length above PAYLOAD_MAX_SIZE SHALL be issued as PAYLOAD_MAX_SIZE, and o_len_err SHALL pulse together with o_start.
REQ-027 i_done SHALL be sampled only in WAIT.
REQ-028 i_done in any other state SHALL be ignored and SHALL not be counted.
REQ-029 In WAIT, i_done SHALL move the FSM to IFG and increment o_frame_cnt, which wraps from 0xFFFFFFFF to 0.
REQ-030 IFG SHALL last exactly IFG_CYCLES cycles, then return to IDLE; requests SHALL not be granted during IFG.
REQ-031 Requests dropped before being sampled in IDLE SHALL be lost without any side effect; the scheduler keeps no request memory.

Reset
REQ-032 While i_rst is high, the following SHALL be cleared immediately, independent of clk: state to IDLE, rr_ptr, o_start, o_grant, o_sel, o_payload_length, o_len_err, o_busy, o_timeout, o_frame_cnt and the IFG and watchdog counters.
REQ-033 Reset asserted mid-frame (START, WAIT or IFG) SHALL abort the frame with no o_timeout and no count increment.
REQ-034 The first grant after reset SHALL start its search at index 0.

Configuration
REQ-035 With macro FRAME_SCHED_WDOG_EN defined, a WAIT lasting WDOG_CYCLES cycles without i_done SHALL pulse o_timeout, go to IFG and leave o_frame_cnt unchanged.
REQ-036 With FRAME_SCHED_WDOG_EN defined, i_done in the same cycle as expiry SHALL win: the frame is counted and no o_timeout pulse is issued.
REQ-037 Without FRAME_SCHED_WDOG_EN, WAIT SHALL persist until i_done, o_timeout SHALL be constant 0, and no watchdog counter SHALL be built.

Verification
REQ-038 Reset, i_req=4'b0100 with len 100, i_done 20 cycles after o_start: o_start 1 cycle after the request with o_grant=4'b0100, o_sel=2, length 100, o_frame_cnt=1, next o_start no earlier than 12 cycles after i_done.
REQ-039 i_req=4'b1111 held, i_done returned promptly: grant order 0,1,2,3,0, each pair separated by START, WAIT and 12 IFG cycles.
REQ-040 Length 10 gives o_payload_length=46 with no o_len_err; length 2000 gives 1500 with o_len_err pulsed alongside o_start.
REQ-041 i_done pulsed while IDLE and during the IFG state: no state change and o_frame_cnt unchanged.
REQ-042 i_rst asserted during WAIT with rr_ptr=2: all outputs at 0 immediately; after release with i_req=4'b1100 the grant goes to index 2.
REQ-043 With FRAME_SCHED_WDOG_EN and no i_done: o_timeout pulses 4096 cycles into WAIT and o_frame_cnt stays 0; a second run with i_done on the expiry cycle gives o_frame_cnt=1 and no o_timeout.
